// File: rtl/imem_pkg.sv
// Shared types and defaults for the writable instruction memory.
//   imem_state_t      : sequencer state (sweep in progress / serving traffic)
//   IMEM_NOP_DEFAULT  : default word written by the init sweep
package imem_pkg;

    typedef enum logic {
        IMEM_INIT  = 1'b0,
        IMEM_READY = 1'b1
    } imem_state_t;

    localparam int unsigned IMEM_DATA_W_DEFAULT = 32;
    localparam int unsigned IMEM_DEPTH_DEFAULT  = 8;
    localparam logic [31:0] IMEM_NOP_DEFAULT    = 32'h0000_0000;

endpackage

// File: rtl/imem_array.sv
// Word-addressed storage with one synchronous write port and one synchronous read port.
// A read and a write to the same address on the same edge return the write data.
// The storage is not reset; only the read data register is, to RDATA_RST.
//   clk, reset    : clock, synchronous active-high reset (read register only)
//   we/waddr/wdata: write port
//   re/raddr      : read port; rdata updates only on edges where re=1
//   rdata         : registered read data, holds between reads
module imem_array
    import imem_pkg::*;
#(
    parameter int unsigned          DATA_W    = IMEM_DATA_W_DEFAULT,
    parameter int unsigned          DEPTH     = IMEM_DEPTH_DEFAULT,
    parameter logic [DATA_W-1:0]    RDATA_RST = '0,
    localparam int unsigned         ADDR_W    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Write-first: a same-address write on this edge bypasses the array.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= RDATA_RST;
        end else if (re) begin
            rdata_q <= (we && (waddr == raddr)) ? wdata : mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/instruction_memory_rw.sv
// Writable instruction store for the fetch stage.
// After reset a sequencer writes NOP_WORD to every word (DEPTH cycles), then the block
// accepts loads and single-cycle-latency fetches, one per cycle.
//   clk, reset                    : clock, synchronous active-high reset
//   fetch_req, fetch_addr         : fetch request, accepted only while fetch_ready=1
//   fetch_ready                   : high once the init sweep has finished
//   instr_valid                   : one-cycle pulse per accepted fetch
//   instruction, instr_addr       : fetched word and its address; hold between fetches
//   load_en, load_addr, load_data : write strobe, honoured only while fetch_ready=1
//   init_busy                     : high while the init sweep runs
module instruction_memory_rw
    import imem_pkg::*;
#(
    parameter int unsigned       DATA_W   = IMEM_DATA_W_DEFAULT,
    parameter int unsigned       DEPTH    = IMEM_DEPTH_DEFAULT,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(IMEM_NOP_DEFAULT)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      fetch_req,
    input  logic [$clog2(DEPTH)-1:0]  fetch_addr,
    output logic                      fetch_ready,
    output logic                      instr_valid,
    output logic [DATA_W-1:0]         instruction,
    output logic [$clog2(DEPTH)-1:0]  instr_addr,
    input  logic                      load_en,
    input  logic [$clog2(DEPTH)-1:0]  load_addr,
    input  logic [DATA_W-1:0]         load_data,
    output logic                      init_busy
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    imem_state_t       state_q, state_d;
    logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
    logic              valid_q;
    logic [ADDR_W-1:0] iaddr_q;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_re;

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        init_busy   = 1'b0;
        fetch_ready = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = load_addr;
        mem_wdata   = load_data;
        mem_re      = 1'b0;

        case (state_q)
            IMEM_INIT: begin
                init_busy  = 1'b1;
                mem_we     = 1'b1;
                mem_waddr  = init_cnt_q;
                mem_wdata  = NOP_WORD;
                init_cnt_d = init_cnt_q + ADDR_W'(1);
                if (init_cnt_q == LAST_ADDR) begin
                    state_d = IMEM_READY;
                end
            end
            IMEM_READY: begin
                fetch_ready = 1'b1;
                mem_we      = load_en;
                mem_re      = fetch_req;
            end
            default: begin
                state_d = IMEM_INIT;
            end
        endcase

        // A reset edge drops whatever is in flight: no write lands, no read is issued.
        if (reset) begin
            mem_we = 1'b0;
            mem_re = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IMEM_INIT;
            init_cnt_q <= '0;
            valid_q    <= 1'b0;
            iaddr_q    <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            valid_q    <= mem_re;
            if (mem_re) begin
                iaddr_q <= fetch_addr;
            end
        end
    end

    imem_array #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .RDATA_RST (NOP_WORD)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .re    (mem_re),
        .raddr (fetch_addr),
        .rdata (instruction)
    );

    assign instr_valid = valid_q;
    assign instr_addr  = iaddr_q;

endmodule

// File: tb/tb_instruction_memory_rw.sv
// Drives two instances (32x8 and 16x32) with the same stimulus and checks both against a
// behavioural model: a cycles-left counter for the sweep and a plain array for storage.
module tb_instruction_memory_rw;

    localparam int DEPTH_A = 8;
    localparam int DEPTH_B = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic [4:0]  fetch_addr;
    logic        load_en;
    logic [4:0]  load_addr;
    logic [31:0] load_data;

    logic        a_ready, a_valid, a_busy;
    logic [31:0] a_instr;
    logic [2:0]  a_iaddr;
    logic        b_ready, b_valid, b_busy;
    logic [15:0] b_instr;
    logic [4:0]  b_iaddr;

    always #5 clk = ~clk;

    instruction_memory_rw #(
        .DATA_W   (32),
        .DEPTH    (DEPTH_A),
        .NOP_WORD (32'h0000_0000)
    ) dut_a (
        .clk         (clk),
        .reset       (reset),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr[2:0]),
        .fetch_ready (a_ready),
        .instr_valid (a_valid),
        .instruction (a_instr),
        .instr_addr  (a_iaddr),
        .load_en     (load_en),
        .load_addr   (load_addr[2:0]),
        .load_data   (load_data),
        .init_busy   (a_busy)
    );

    instruction_memory_rw #(
        .DATA_W   (16),
        .DEPTH    (DEPTH_B),
        .NOP_WORD (16'h0000)
    ) dut_b (
        .clk         (clk),
        .reset       (reset),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_ready (b_ready),
        .instr_valid (b_valid),
        .instruction (b_instr),
        .instr_addr  (b_iaddr),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data[15:0]),
        .init_busy   (b_busy)
    );

    // Reference model, index 0 = instance A, 1 = instance B.
    logic [31:0] m_mem [2][32];
    int          m_left [2];
    logic        m_valid [2];
    logic [31:0] m_instr [2];
    logic [31:0] m_iaddr [2];

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Applies the rules to the inputs present at the edge.
    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            int          dep;
            int          fa;
            int          la;
            logic [31:0] d;
            dep = (i == 0) ? DEPTH_A : DEPTH_B;
            fa  = int'(fetch_addr) % dep;
            la  = int'(load_addr) % dep;
            d   = (i == 0) ? load_data : (load_data & 32'h0000_FFFF);
            if (reset) begin
                m_left[i]  = dep;
                m_valid[i] = 1'b0;
                m_instr[i] = 32'h0;
                m_iaddr[i] = 32'h0;
                for (int k = 0; k < 32; k++) m_mem[i][k] = 32'h0;
            end else if (m_left[i] > 0) begin
                m_left[i]--;
                m_valid[i] = 1'b0;
            end else begin
                m_valid[i] = fetch_req;
                if (fetch_req) begin
                    m_iaddr[i] = 32'(fa);
                    m_instr[i] = (load_en && la == fa) ? d : m_mem[i][fa];
                end
                if (load_en) m_mem[i][la] = d;
            end
        end
    endtask

    task automatic check_all();
        chk("a_busy",  32'(a_busy),  32'(m_left[0] > 0));
        chk("a_ready", 32'(a_ready), 32'(m_left[0] == 0));
        chk("a_valid", 32'(a_valid), 32'(m_valid[0]));
        chk("a_instr", a_instr,      m_instr[0]);
        chk("a_iaddr", 32'(a_iaddr), m_iaddr[0]);
        chk("b_busy",  32'(b_busy),  32'(m_left[1] > 0));
        chk("b_ready", 32'(b_ready), 32'(m_left[1] == 0));
        chk("b_valid", 32'(b_valid), 32'(m_valid[1]));
        chk("b_instr", 32'(b_instr), m_instr[1]);
        chk("b_iaddr", 32'(b_iaddr), m_iaddr[1]);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle();
        fetch_req = 1'b0;
        load_en   = 1'b0;
        reset     = 1'b0;
    endtask

    // Counts busy cycles of each instance until both are ready (bounded).
    task automatic wait_ready(output int ca, output int cb);
        ca = 0;
        cb = 0;
        for (int k = 0; k < 100 && (a_busy || b_busy); k++) begin
            if (a_busy) ca++;
            if (b_busy) cb++;
            step();
        end
    endtask

    int ca, cb, pulses;

    initial begin
        reset      = 1'b1;
        fetch_req  = 1'b0;
        fetch_addr = '0;
        load_en    = 1'b0;
        load_addr  = '0;
        load_data  = '0;
        for (int i = 0; i < 2; i++) m_left[i] = 0;
        step();
        step();
        reset = 1'b0;

        // 1: sweep length, then every word reads NOP
        wait_ready(ca, cb);
        chk("init_cycles_a", 32'(ca), 32'd8);
        chk("init_cycles_b", 32'(cb), 32'd32);
        for (int k = 0; k < 8; k++) begin
            fetch_req  = 1'b1;
            fetch_addr = 5'(k);
            step();
            chk("t1_nop_a", a_instr, 32'h0);
        end
        idle();
        step();

        // 2: load then fetch
        load_en = 1'b1; load_addr = 5'd3; load_data = 32'hDEADBEEF;
        step();
        idle();
        fetch_req = 1'b1; fetch_addr = 5'd3;
        step();
        idle();
        chk("t2_valid_a", 32'(a_valid), 32'd1);
        chk("t2_instr_a", a_instr, 32'hDEADBEEF);
        chk("t2_iaddr_a", 32'(a_iaddr), 32'd3);
        chk("t2_instr_b", 32'(b_instr), 32'h0000BEEF);
        step();

        // 3: same-cycle load and fetch are write-first
        load_en = 1'b1; load_addr = 5'd5; load_data = 32'h12345678;
        fetch_req = 1'b1; fetch_addr = 5'd5;
        step();
        idle();
        chk("t3_instr_a", a_instr, 32'h12345678);
        chk("t3_instr_b", 32'(b_instr), 32'h00005678);

        // 4: full-throughput burst
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            fetch_req  = 1'b1;
            fetch_addr = 5'(k);
            step();
            if (a_valid) pulses++;
        end
        idle();
        chk("t4_pulses_a", 32'(pulses), 32'd8);
        step();

        // 5: reset mid-sweep, then reset with a fetch in flight
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        wait_ready(ca, cb);
        chk("t5_restart_a", 32'(ca), 32'd8);
        chk("t5_restart_b", 32'(cb), 32'd32);
        load_en = 1'b1; load_addr = 5'd2; load_data = 32'hCAFEF00D;
        step();
        idle();
        fetch_req = 1'b1; fetch_addr = 5'd2; reset = 1'b1;
        step();
        idle();
        chk("t5_no_valid_a", 32'(a_valid), 32'd0);
        wait_ready(ca, cb);
        fetch_req = 1'b1; fetch_addr = 5'd2;
        step();
        idle();
        chk("t5_cleared_a", a_instr, 32'h0);
        chk("t5_cleared_b", 32'(b_instr), 32'h0);

        // 6: traffic during the sweep is ignored
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 0; k < 100 && a_busy; k++) begin
            fetch_req = 1'b1;
            fetch_addr = 5'($urandom);
            load_en = 1'b1;
            load_addr = 5'($urandom);
            load_data = $urandom | 32'h1;
            step();
            chk("t6_no_valid_a", 32'(a_valid), 32'd0);
        end
        idle();
        for (int k = 0; k < 8; k++) begin
            fetch_req = 1'b1; fetch_addr = 5'(k);
            step();
            chk("t6_nop_a", a_instr, 32'h0);
        end
        idle();
        wait_ready(ca, cb);
        for (int k = 0; k < 32; k++) begin
            fetch_req = 1'b1; fetch_addr = 5'(k);
            step();
            chk("t6_nop_b", 32'(b_instr), 32'h0);
        end
        idle();

        // 7: random traffic, occasional reset
        for (int k = 0; k < 400; k++) begin
            reset      = ($urandom_range(0, 60) == 0);
            fetch_req  = 1'($urandom);
            fetch_addr = 5'($urandom);
            load_en    = 1'($urandom);
            load_addr  = ($urandom_range(0, 3) == 0) ? fetch_addr : 5'($urandom);
            load_data  = $urandom;
            step();
        end
        idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
